// File: rtl/icache.sv
// Direct-mapped instruction cache, one 32-bit word per entry, with a blocking
// single-outstanding miss path to the memory controller.
module icache #(
   parameter int ENTRY_BITS = 6
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rdy,
   input  logic        jump_rst,
   input  logic        fetch_valid,
   input  logic [31:0] fetch_pc,
   output logic        inst_ready,
   output logic [31:0] inst,
   output logic [31:0] inst_pc,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   input  logic        mem_done,
   input  logic [31:0] mem_inst
);

   localparam int ENTRIES = 1 << ENTRY_BITS;
   localparam int TAG_W   = 30 - ENTRY_BITS;

   typedef enum logic {S_IDLE, S_MISS} state_e;

   state_e             state_q, state_d;
   logic [ENTRIES-1:0] valid_q, valid_d;
   logic               inst_ready_q, inst_ready_d;
   logic [31:0]        inst_q, inst_d;
   logic [31:0]        inst_pc_q, inst_pc_d;
   logic               mem_req_q, mem_req_d;
   logic [31:0]        mem_addr_q, mem_addr_d;
   logic [31:0]        miss_pc_q, miss_pc_d;
   logic               fill_we;

   logic [TAG_W-1:0]   tag_mem  [ENTRIES];
   logic [31:0]        data_mem [ENTRIES];

   logic [ENTRY_BITS-1:0] fetch_idx, miss_idx;
   logic [TAG_W-1:0]      fetch_tag, miss_tag;
   logic                  hit;

   assign fetch_idx = fetch_pc[ENTRY_BITS+1:2];
   assign fetch_tag = fetch_pc[31:ENTRY_BITS+2];
   assign miss_idx  = miss_pc_q[ENTRY_BITS+1:2];
   assign miss_tag  = miss_pc_q[31:ENTRY_BITS+2];
   assign hit       = valid_q[fetch_idx] && (tag_mem[fetch_idx] == fetch_tag);

   always_comb begin
      state_d      = state_q;
      valid_d      = valid_q;
      inst_ready_d = inst_ready_q;
      inst_d       = inst_q;
      inst_pc_d    = inst_pc_q;
      mem_req_d    = mem_req_q;
      mem_addr_d   = mem_addr_q;
      miss_pc_d    = miss_pc_q;
      fill_we      = 1'b0;
      // A flush overrides everything, including a fill landing the same cycle.
      if (jump_rst) begin
         state_d      = S_IDLE;
         inst_ready_d = 1'b0;
         mem_req_d    = 1'b0;
         mem_addr_d   = 32'h0;
      end else if (rdy) begin
         inst_ready_d = 1'b0;
         unique case (state_q)
            S_IDLE: begin
               if (fetch_valid && !inst_ready_q) begin
                  if (hit) begin
                     inst_ready_d = 1'b1;
                     inst_d       = data_mem[fetch_idx];
                     inst_pc_d    = fetch_pc;
                  end else begin
                     state_d    = S_MISS;
                     mem_req_d  = 1'b1;
                     mem_addr_d = {fetch_pc[31:2], 2'b00};
                     miss_pc_d  = fetch_pc;
                  end
               end
            end
            S_MISS: begin
               if (mem_done) begin
                  fill_we            = 1'b1;
                  valid_d[miss_idx]  = 1'b1;
                  inst_ready_d       = 1'b1;
                  inst_d             = mem_inst;
                  inst_pc_d          = miss_pc_q;
                  mem_req_d          = 1'b0;
                  mem_addr_d         = 32'h0;
                  state_d            = S_IDLE;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         valid_q      <= '0;
         inst_ready_q <= 1'b0;
         inst_q       <= 32'h0;
         inst_pc_q    <= 32'h0;
         mem_req_q    <= 1'b0;
         mem_addr_q   <= 32'h0;
         miss_pc_q    <= 32'h0;
      end else begin
         state_q      <= state_d;
         valid_q      <= valid_d;
         inst_ready_q <= inst_ready_d;
         inst_q       <= inst_d;
         inst_pc_q    <= inst_pc_d;
         mem_req_q    <= mem_req_d;
         mem_addr_q   <= mem_addr_d;
         miss_pc_q    <= miss_pc_d;
      end
   end

   // Tag/data storage needs no reset; the valid bits gate every lookup.
   always_ff @(posedge clk) begin
      if (!rst && fill_we) begin
         tag_mem[miss_idx]  <= miss_tag;
         data_mem[miss_idx] <= mem_inst;
      end
   end

   assign inst_ready = inst_ready_q;
   assign inst       = inst_q;
   assign inst_pc    = inst_pc_q;
   assign mem_req    = mem_req_q;
   assign mem_addr   = mem_addr_q;

endmodule

// File: tb/tb_icache.sv
// Directed plus randomized bench for icache; a transaction-level cache model
// predicts hit/miss and returned words.
module tb_icache;

   logic        clk = 1'b0;
   logic        rst, rdy, jump_rst, fetch_valid, mem_done;
   logic [31:0] fetch_pc, mem_inst;
   logic        inst_ready, mem_req;
   logic [31:0] inst, inst_pc, mem_addr;

   int vectors = 0;
   int errors  = 0;

   logic [31:0] exp_q[$];
   logic [31:0] exp_pc_q[$];
   logic [31:0] last_inst;

   // Reference cache: 64 entries, index = word address mod 64, tag = pc / 256.
   bit          m_valid [64];
   logic [23:0] m_tag   [64];
   logic [31:0] m_data  [64];

   always #5 clk = ~clk;

   icache #(.ENTRY_BITS(6)) dut (
      .clk         (clk),
      .rst         (rst),
      .rdy         (rdy),
      .jump_rst    (jump_rst),
      .fetch_valid (fetch_valid),
      .fetch_pc    (fetch_pc),
      .inst_ready  (inst_ready),
      .inst        (inst),
      .inst_pc     (inst_pc),
      .mem_req     (mem_req),
      .mem_addr    (mem_addr),
      .mem_done    (mem_done),
      .mem_inst    (mem_inst)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   task automatic model_clear();
      for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;
      exp_q.delete();
      exp_pc_q.delete();
   endtask

   task automatic do_reset();
      rst = 1'b1; rdy = 1'b1; jump_rst = 1'b0; fetch_valid = 1'b0;
      fetch_pc = 32'h0; mem_done = 1'b0; mem_inst = 32'h0;
      tick();
      tick();
      rst = 1'b0;
      model_clear();
      last_inst = 32'h0;
   endtask

   task automatic check_zero_outputs(input string tag);
      chk({tag, "_inst_ready"}, {31'h0, inst_ready}, 32'h0);
      chk({tag, "_inst"},       inst,                32'h0);
      chk({tag, "_inst_pc"},    inst_pc,             32'h0);
      chk({tag, "_mem_req"},    {31'h0, mem_req},    32'h0);
      chk({tag, "_mem_addr"},   mem_addr,            32'h0);
   endtask

   // Scoreboard: every pulse pops the oldest expected word/pc.
   task automatic expect_pulse(input string tag);
      logic [31:0] e_inst, e_pc;
      chk({tag, "_ready"}, {31'h0, inst_ready}, 32'h1);
      chk({tag, "_sb_depth"}, exp_q.size(), 32'h1);
      if (exp_q.size() > 0) begin
         e_inst = exp_q.pop_front();
         e_pc   = exp_pc_q.pop_front();
         chk({tag, "_inst"},    inst,    e_inst);
         chk({tag, "_inst_pc"}, inst_pc, e_pc);
         last_inst = e_inst;
      end
   endtask

   // One complete fetch: request, optional miss service, pulse, pulse end.
   task automatic do_fetch(input logic [31:0] pc, input int lat, input int stall,
                           input logic [31:0] word);
      int          idx;
      logic [23:0] tag;
      bit          m_hit;
      idx   = int'((pc >> 2) % 64);
      tag   = pc[31:8];
      m_hit = m_valid[idx] && (m_tag[idx] == tag);
      fetch_valid = 1'b1;
      fetch_pc    = pc;
      tick();
      if (m_hit) begin
         exp_q.push_back(m_data[idx]);
         exp_pc_q.push_back(pc);
         fetch_valid = 1'b0;
         fetch_pc    = $urandom;
         expect_pulse("hit");
         chk("hit_mem_req", {31'h0, mem_req}, 32'h0);
      end else begin
         chk("miss_req",      {31'h0, mem_req},    32'h1);
         chk("miss_addr",     mem_addr,            pc & 32'hFFFF_FFFC);
         chk("miss_no_ready", {31'h0, inst_ready}, 32'h0);
         for (int i = 0; i < lat + stall; i++) begin
            rdy      = (i < lat) ? 1'($urandom_range(0, 1)) : 1'b0;
            mem_inst = $urandom;
            tick();
            chk("wait_req",      {31'h0, mem_req},    32'h1);
            chk("wait_addr",     mem_addr,            pc & 32'hFFFF_FFFC);
            chk("wait_no_ready", {31'h0, inst_ready}, 32'h0);
         end
         rdy      = 1'b1;
         mem_done = 1'b1;
         mem_inst = word;
         tick();
         mem_done    = 1'b0;
         mem_inst    = $urandom;
         fetch_valid = 1'b0;
         fetch_pc    = $urandom;
         m_valid[idx] = 1'b1;
         m_tag[idx]   = tag;
         m_data[idx]  = word;
         exp_q.push_back(word);
         exp_pc_q.push_back(pc);
         expect_pulse("fill");
         chk("fill_req_drop",  {31'h0, mem_req}, 32'h0);
         chk("fill_addr_zero", mem_addr,         32'h0);
      end
      tick();
      chk("pulse_end", {31'h0, inst_ready}, 32'h0);
      chk("inst_hold", inst, last_inst);
   endtask

   initial begin
      logic [31:0] pc;
      do_reset();
      check_zero_outputs("reset");

      // Cold miss, then hit on the same address.
      do_fetch(32'h0000_0104, 2, 0, 32'h0000_0513);
      do_fetch(32'h0000_0104, 0, 0, 32'h0);

      // Index conflict: 0x204 evicts 0x104, which then misses again.
      do_fetch(32'h0000_0204, 1, 0, 32'h1111_2222);
      do_fetch(32'h0000_0104, 0, 0, 32'h0000_0513);

      // mem_done while idle must not fill or pulse.
      mem_done = 1'b1;
      mem_inst = 32'hBAD0_BAD0;
      tick();
      mem_done = 1'b0;
      chk("idle_done_no_ready", {31'h0, inst_ready}, 32'h0);
      chk("idle_done_no_req",   {31'h0, mem_req},    32'h0);
      tick();
      chk("idle_done_no_ready2", {31'h0, inst_ready}, 32'h0);
      do_fetch(32'h0000_0104, 0, 0, 32'h0);

      // Flush colliding with mem_done; fetch accepted right after the flush.
      fetch_valid = 1'b1;
      fetch_pc    = 32'h0000_0300;
      tick();
      chk("flush_miss_req", {31'h0, mem_req}, 32'h1);
      jump_rst    = 1'b1;
      mem_done    = 1'b1;
      mem_inst    = 32'hDEAD_BEEF;
      fetch_valid = 1'b0;
      tick();
      jump_rst = 1'b0;
      mem_done = 1'b0;
      chk("flush_req",      {31'h0, mem_req},    32'h0);
      chk("flush_addr",     mem_addr,            32'h0);
      chk("flush_no_ready", {31'h0, inst_ready}, 32'h0);
      do_fetch(32'h0000_0300, 1, 0, 32'h0300_0001);

      // Five rdy-low cycles in the middle of a miss.
      do_fetch(32'h0000_0400, 0, 5, 32'h0400_0002);

      // Reset during a miss wipes the valid bits.
      fetch_valid = 1'b1;
      fetch_pc    = 32'h0000_0500;
      tick();
      chk("rstmiss_req", {31'h0, mem_req}, 32'h1);
      rst         = 1'b1;
      fetch_valid = 1'b0;
      tick();
      rst = 1'b0;
      model_clear();
      last_inst = 32'h0;
      check_zero_outputs("rst_mid_miss");
      do_fetch(32'h0000_0104, 1, 0, 32'h0000_0777);

      // Random fetches over 4 tags x 16 indexes, with random latency and stalls.
      for (int n = 0; n < 80; n++) begin
         pc = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 15)) << 2)
              | 32'($urandom_range(0, 3));
         do_fetch(pc, $urandom_range(0, 3), $urandom_range(0, 1), $urandom);
      end

      chk("sb_drained", exp_q.size(), 32'h0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule

// File: doc/icache.md
ICACHE -- requirements
Module: icache

Interface
REQ-001 Parameter ENTRY_BITS, default 6, log2 of the number of direct-mapped entries (64 entries, one 32-bit instruction word each).
REQ-002 clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 rdy  input  1  global enable; when low, the block holds all state and outputs.
REQ-005 jump_rst  input  1  pipeline flush on a mispredicted or taken jump.
REQ-006 fetch_valid  input  1  fetch stage requests the instruction at fetch_pc.
REQ-007 fetch_pc  input  32  byte address of the requested instruction.
REQ-008 inst_ready  output  1  one-cycle pulse: inst/inst_pc valid.
REQ-009 inst  output  32  returned instruction word.
REQ-010 inst_pc  output  32  address of the returned instruction.
REQ-011 mem_req  output  1  miss request to the memory controller (drives its IF_valid).
REQ-012 mem_addr  output  32  word-aligned miss address (drives its IF_addr).
REQ-013 mem_done  input  1  memory controller word-complete pulse (its IF_send).
REQ-014 mem_inst  input  32  fetched word, valid while mem_done=1 (its IF_inst).

Function
REQ-015 Indexing: index = pc[ENTRY_BITS+1:2]; tag = pc[31:ENTRY_BITS+2]; pc[1:0] ignored; each entry holds a valid bit, tag and 32-bit data.
REQ-016 FSM states: IDLE, MISS; all transitions and output updates are qualified by rdy=1 (rdy=0: no change anywhere).
REQ-017 IDLE, fetch_valid=1, inst_ready currently 0, entry valid and tag match (hit): next cycle inst_ready=1, inst=entry data, inst_pc=fetch_pc; state stays IDLE.
REQ-018 IDLE, fetch_valid=1, inst_ready currently 0, miss: next cycle state=MISS, mem_req=1, mem_addr={fetch_pc[31:2],2'b00}, fetch_pc latched internally.
REQ-019 While inst_ready=1, fetch_valid is ignored (the fetch stage updates fetch_pc on that edge); hit throughput is one instruction per 2 cycles.
REQ-020 Fetch contract: fetch_pc is held stable while fetch_valid=1 until inst_ready is seen; the cache relies on this and does not re-check fetch_pc during MISS.
REQ-021 MISS: mem_req and mem_addr held constant until mem_done=1.
REQ-022 MISS with mem_done=1: entry at latched index written (valid=1, latched tag, data=mem_inst); next cycle inst_ready=1, inst=mem_inst, inst_pc=latched pc, mem_req=0, state=IDLE.
REQ-023 mem_req drops to 0 in the cycle after mem_done; mem_addr returns to 0 at the same time.
REQ-024 mem_done while in IDLE is ignored (no fill, no inst_ready).
REQ-025 inst_ready is a single-cycle pulse; inst and inst_pc hold their last values when inst_ready=0.
REQ-026 jump_rst=1 (rdy-independent): next cycle state=IDLE, mem_req=0, mem_addr=0, inst_ready=0; tag/data/valid arrays retained.
REQ-027 jump_rst and mem_done in the same cycle: jump_rst wins; no fill, no inst_ready.
REQ-028 A new fetch_valid is accepted on the cycle after a jump_rst cycle.
REQ-029 Fills overwrite the entry unconditionally (replacement by index conflict only); there is no self-modifying-code coherence requirement.

Reset
REQ-030 rst=1 (rdy-independent): state=IDLE, all valid bits=0, inst_ready=0, inst=0, inst_pc=0, mem_req=0, mem_addr=0.
REQ-031 rst has priority over jump_rst, rdy and every other input.

Verification
REQ-032 Cold miss: after reset, fetch_pc=0x0000_0104 -> mem_req=1, mem_addr=0x104; mem_done with mem_inst=0x0000_0513 -> next cycle inst_ready=1, inst=0x00000513, inst_pc=0x104, mem_req=0.
REQ-033 Hit: refetch 0x104 -> inst_ready exactly one cycle after acceptance, mem_req stays 0, inst=0x00000513.
REQ-034 Conflict: fill 0x104, then fetch 0x204 (same index 1, different tag) -> miss issued with mem_addr=0x204; next fetch 0x104 misses again.
REQ-035 Flush mid-miss: fetch 0x300 misses; jump_rst asserted together with mem_done -> mem_req=0, no inst_ready, fetch 0x300 afterwards misses again.
REQ-036 Stall: rdy=0 for 5 cycles during MISS with mem_done held low -> mem_req/mem_addr unchanged; inst_ready never asserts.
REQ-037 Reset mid-miss: rst during MISS -> all outputs 0; previously filled 0x104 now misses.
